baudrg_frac_module: RTL and testbench
=====================================

Name: baudrg_frac_module

Overview:
Runtime-programmable fractional baud-rate generator, successor to the fixed integer mod-M tick generator in the UART path. Produces an oversampling tick (nominally 16x baud) with average period DIV_INT + DIV_FRAC/2^NB_FRAC clocks. Derives a per-bit tick and a mid-bit sampling tick for the UART TX/RX FSMs, and supports phase resync on an RX start edge.

Parameters:
NB_DIV, 16, width of integer divisor and period counter
NB_FRAC, 4, width of fractional divisor and phase accumulator
OVERSAMPLE, 16, oversampling ticks per bit (power of 2, >=4)
NB_OVS, 4, width of oversample counter (log2 OVERSAMPLE)
DEFAULT_DIV_INT, 325, integer divisor after reset (50 MHz, 9600 baud x16)
DEFAULT_DIV_FRAC, 8, fractional divisor after reset (325.5 average)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_enable  in  1  count enable; low freezes all state
i_load  in  1  one-cycle strobe, applies i_div_int/i_div_frac
i_div_int  in  NB_DIV  new integer divisor (valid >= 2)
i_div_frac  in  NB_FRAC  new fractional divisor, units of 1/2^NB_FRAC
i_resync  in  1  one-cycle strobe, restarts tick and bit phase
o_tick  out  1  oversample tick, 1-cycle pulse
o_bit_tick  out  1  pulse on tick completing a bit (ovs wraps OVERSAMPLE-1 -> 0)
o_mid_tick  out  1  pulse on tick where ovs == OVERSAMPLE/2-1 (mid-bit sample point)
o_cfg_err  out  1  sticky: last load rejected

Behaviour:
- Clock i_clk; reset asynchronous, active-low (i_reset_n). Reset: cnt=0, acc=0, ovs=0, div_q=DEFAULT_DIV_INT, frac_q=DEFAULT_DIV_FRAC; all outputs 0.
- Carry c = carry-out of (acc + frac_q) over NB_FRAC bits. Terminal value last = div_q - 1 + c.
- Enabled, no strobe: cnt==last -> cnt<=0, acc<=(acc+frac_q) mod 2^NB_FRAC, ovs<=ovs+1 (wraps at OVERSAMPLE-1); else cnt<=cnt+1.
- Outputs are registered: o_tick<=1 in the cycle after cnt==last with enable high; 0 otherwise. Fixed latency of 1 clock; the period is unaffected.
- o_bit_tick / o_mid_tick are registered alongside o_tick and are asserted only when o_tick is asserted, using the pre-increment ovs value.
- Tick spacing is always div_q or div_q+1 clocks. Over 2^NB_FRAC ticks, exactly frac_q ticks are long. frac_q=0 gives an exact integer period identical to the legacy mod-M block.
- i_enable low: cnt, acc, and ovs hold; all pulse outputs are 0 the next cycle; i_load and i_resync still act.
- i_load with i_div_int >= 2: div_q/frac_q updated; cnt, acc, and ovs cleared; o_cfg_err cleared; no pulses the next cycle.
- i_load with i_div_int < 2: config unchanged, counters unchanged, o_cfg_err<=1 (sticky until a valid load).
- i_resync: cnt<=0, ovs<=0, acc held; pulses suppressed the next cycle. Counting resumes the following cycle, so the first tick comes div_q(+c) clocks after the strobe.
- Precedence: reset > i_load > i_resync > count. Load and resync in the same cycle: load wins (it clears ovs anyway).
- Counter wrap: cnt never exceeds last. If div_q shrinks, only a load changes it, and a load clears cnt, so no overrun is possible.
- Reset asserted mid-period clears immediately (asynchronously). Outputs stay 0 until the first full period after release.

Decomposition:
- Package baudrg_pkg: DEFAULT_DIV_INT, DEFAULT_DIV_FRAC, MIN_DIV_INT=2, OVERSAMPLE defaults, and a function computing the divisor from (clock, baud, oversample).
- Sub-module baudrg_ovs_counter: mod-OVERSAMPLE counter advanced by tick, with a clear input, producing the bit and mid-bit decodes. Top level holds the fractional period counter, config registers, and error flag.

Test Plan:
- Integer mode: load div_int=326, frac=0 -> o_tick every 326 clocks exactly over 100 ticks; o_bit_tick every 16th tick (5216 clocks).
- Fractional default after reset: div 325 + 8/16 -> tick spacings alternate 325/326; 16 ticks span exactly 5208 clocks; o_mid_tick on ticks 8, 24, 40, ...
- Invalid load: div_int=1 -> o_cfg_err=1, spacing stays 325/326. Then load div_int=10, frac=0 -> o_cfg_err=0, first tick 10 clocks after the strobe, period 10.
- Resync mid-bit: pulse i_resync after 5 ticks -> no pulse the next cycle; first tick div clocks later; o_mid_tick on the 8th tick after resync; o_bit_tick on the 16th.
- Enable gating: drop i_enable for 100 clocks mid-period -> no pulses; after re-enable, the remaining period is completed (total enabled clocks between ticks = 325 or 326).
- Async reset mid-period: assert i_reset_n=0 between clock edges -> all outputs 0 immediately; after release, first tick at 325 or 326 clocks per the acc=0 state (325, since c=0).

Source files
------------

// File: rtl/baudrg_pkg.sv
// Shared defaults and divisor helper for the fractional baud-rate generator.
// The divisor helper returns DIV_INT * 2^NB_FRAC + DIV_FRAC, rounded to nearest.
package baudrg_pkg;

  localparam int DEFAULT_NB_DIV     = 16;
  localparam int DEFAULT_NB_FRAC    = 4;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_NB_OVS     = 4;
  localparam int DEFAULT_DIV_INT    = 325;
  localparam int DEFAULT_DIV_FRAC   = 8;
  localparam int MIN_DIV_INT        = 2;

  // Upper bits give i_div_int, the low DEFAULT_NB_FRAC bits give i_div_frac.
  function automatic int unsigned calcDivisor(input int unsigned clkHz,
                                              input int unsigned baud,
                                              input int unsigned oversample);
    longint unsigned den;
    longint unsigned num;
    den = longint'(baud) * longint'(oversample);
    num = longint'(clkHz) << DEFAULT_NB_FRAC;
    if (den == 0) return 0;
    return int'((num + den / 2) / den);
  endfunction

endpackage

// File: rtl/baudrg_ovs_counter.sv
// Mod-OVERSAMPLE counter stepped by each oversample tick; decodes the
// bit-complete and mid-bit positions from the current (pre-increment) count.
module baudrg_ovs_counter
  import baudrg_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int NB_OVS     = DEFAULT_NB_OVS
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_advance,
  output logic o_bit_dec,
  output logic o_mid_dec
);

  logic [NB_OVS-1:0] r_ovs;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ovs <= '0;
    end else if (i_clear) begin
      r_ovs <= '0;
    end else if (i_advance) begin
      if (r_ovs == NB_OVS'(OVERSAMPLE - 1)) r_ovs <= '0;
      else                                  r_ovs <= r_ovs + NB_OVS'(1);
    end
  end

  assign o_bit_dec = (r_ovs == NB_OVS'(OVERSAMPLE - 1));
  assign o_mid_dec = (r_ovs == NB_OVS'(OVERSAMPLE / 2 - 1));

endmodule

// File: rtl/baudrg_frac_module.sv
// Runtime-programmable fractional baud-rate generator: oversample tick with
// average period DIV_INT + DIV_FRAC/2^NB_FRAC, plus bit and mid-bit ticks.
module baudrg_frac_module
  import baudrg_pkg::*;
#(
  parameter int NB_DIV           = DEFAULT_NB_DIV,
  parameter int NB_FRAC          = DEFAULT_NB_FRAC,
  parameter int OVERSAMPLE       = DEFAULT_OVERSAMPLE,
  parameter int NB_OVS           = DEFAULT_NB_OVS,
  parameter int DEFAULT_DIV_INT  = baudrg_pkg::DEFAULT_DIV_INT,
  parameter int DEFAULT_DIV_FRAC = baudrg_pkg::DEFAULT_DIV_FRAC
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_load,
  input  logic [NB_DIV-1:0]  i_div_int,
  input  logic [NB_FRAC-1:0] i_div_frac,
  input  logic               i_resync,
  output logic               o_tick,
  output logic               o_bit_tick,
  output logic               o_mid_tick,
  output logic               o_cfg_err
);

  logic [NB_DIV-1:0]  r_cnt;
  logic [NB_DIV-1:0]  r_div_q;
  logic [NB_FRAC-1:0] r_acc;
  logic [NB_FRAC-1:0] r_frac_q;
  logic               r_cfg_err;
  logic               r_tick;
  logic               r_bit_tick;
  logic               r_mid_tick;

  logic [NB_FRAC:0]   w_acc_sum;
  logic               w_carry;
  logic [NB_DIV-1:0]  w_last;
  logic               w_load_ok;
  logic               w_wrap;
  logic               w_bit_dec;
  logic               w_mid_dec;

  // A carry out of the phase accumulator stretches this period by one clock.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac_q};
  assign w_carry   = w_acc_sum[NB_FRAC];
  assign w_last    = r_div_q - NB_DIV'(1) + NB_DIV'(w_carry);
  assign w_load_ok = i_load && (i_div_int >= NB_DIV'(MIN_DIV_INT));
  assign w_wrap    = i_enable && !w_load_ok && !i_resync && (r_cnt == w_last);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_div_q   <= NB_DIV'(DEFAULT_DIV_INT);
      r_frac_q  <= NB_FRAC'(DEFAULT_DIV_FRAC);
      r_cfg_err <= 1'b0;
    end else if (w_load_ok) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_div_q   <= i_div_int;
      r_frac_q  <= i_div_frac;
      r_cfg_err <= 1'b0;
    end else begin
      // A rejected load only flags the error; counting carries on untouched.
      if (i_load) r_cfg_err <= 1'b1;
      if (i_resync) begin
        r_cnt <= '0;
      end else if (i_enable) begin
        if (r_cnt == w_last) begin
          r_cnt <= '0;
          r_acc <= w_acc_sum[NB_FRAC-1:0];
        end else begin
          r_cnt <= r_cnt + NB_DIV'(1);
        end
      end
    end
  end

  baudrg_ovs_counter #(
    .OVERSAMPLE (OVERSAMPLE),
    .NB_OVS     (NB_OVS)
  ) u_ovs (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_load_ok || i_resync),
    .i_advance (w_wrap),
    .o_bit_dec (w_bit_dec),
    .o_mid_dec (w_mid_dec)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tick     <= 1'b0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
    end else begin
      r_tick     <= w_wrap;
      r_bit_tick <= w_wrap && w_bit_dec;
      r_mid_tick <= w_wrap && w_mid_dec;
    end
  end

  assign o_tick     = r_tick;
  assign o_bit_tick = r_bit_tick;
  assign o_mid_tick = r_mid_tick;
  assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_baudrg_frac_module.sv
// Directed bench for baudrg_frac_module: tick spacing, bit/mid decodes,
// load/resync/enable behaviour and asynchronous reset.
module tb_baudrg_frac_module;

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable;
  logic        load;
  logic        resync;
  logic [15:0] divInt;
  logic [3:0]  divFrac;
  logic        tick;
  logic        bitTick;
  logic        midTick;
  logic        cfgErr;

  int cycleCnt = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  baudrg_frac_module dut (
    .i_clk      (clk),
    .i_reset_n  (resetN),
    .i_enable   (enable),
    .i_load     (load),
    .i_div_int  (divInt),
    .i_div_frac (divFrac),
    .i_resync   (resync),
    .o_tick     (tick),
    .o_bit_tick (bitTick),
    .o_mid_tick (midTick),
    .o_cfg_err  (cfgErr)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one-cycle strobes on a falling edge, release them on the next one.
  task automatic applyStimulus(input logic ld, input int di, input int df, input logic rs);
    load    = ld;
    divInt  = 16'(di);
    divFrac = 4'(df);
    resync  = rs;
    @(negedge clk);
    load   = 1'b0;
    resync = 1'b0;
  endtask

  task automatic waitTick(input int limit, output int when, output logic b, output logic m);
    bit found;
    found = 0;
    when  = -1;
    b     = 1'b0;
    m     = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        found = 1;
        when  = cycleCnt;
        b     = bitTick;
        m     = midTick;
      end
    end
    if (!found) checkOutput("tick_timeout", 0, 1);
  endtask

  // Reference phase accumulator for the default 325 + 8/16 setting.
  int accModel;
  function automatic int nextGap();
    int sum;
    sum      = accModel + 8;
    accModel = sum % 16;
    return 325 + ((sum >= 16) ? 1 : 0);
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, prevT, t1, gap, pulses, okGaps, bitCnt, midCnt, lastBit;
    logic b, m;

    resetN  = 1'b0;
    enable  = 1'b1;
    load    = 1'b0;
    resync  = 1'b0;
    divInt  = '0;
    divFrac = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tick", tick, 0);
    checkOutput("reset_bit", bitTick, 0);
    checkOutput("reset_mid", midTick, 0);
    checkOutput("reset_err", cfgErr, 0);

    // Default fractional mode straight out of reset.
    resetN   = 1'b1;
    prevT    = cycleCnt;
    accModel = 0;
    t1       = 0;
    for (int k = 1; k <= 32; k++) begin
      gap = nextGap();
      waitTick(400, t, b, m);
      checkOutput($sformatf("frac_gap%0d", k), t - prevT, gap);
      checkOutput($sformatf("frac_mid%0d", k), m, ((k - 1) % 16 == 7) ? 1 : 0);
      checkOutput($sformatf("frac_bit%0d", k), b, ((k - 1) % 16 == 15) ? 1 : 0);
      if (k == 1) t1 = t;
      if (k == 17) checkOutput("frac_span16", t - t1, 5208);
      prevT = t;
    end

    // Enable gating: 50 enabled clocks, 100 frozen, then finish the period.
    gap    = nextGap();
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      pulses += int'(tick) + int'(bitTick) + int'(midTick);
    end
    enable = 1'b0;
    repeat (100) begin
      @(negedge clk);
      pulses += int'(tick) + int'(bitTick) + int'(midTick);
    end
    enable = 1'b1;
    checkOutput("gated_pulses", pulses, 0);
    waitTick(400, t, b, m);
    checkOutput("gated_gap", t - prevT, gap + 100);
    prevT = t;

    // Rejected load flags an error but leaves the 325/326 cadence running.
    applyStimulus(1'b1, 1, 0, 1'b0);
    checkOutput("inv_err_set", cfgErr, 1);
    gap = nextGap();
    waitTick(400, t, b, m);
    prevT = t;
    for (int k = 1; k <= 3; k++) begin
      gap = nextGap();
      waitTick(400, t, b, m);
      checkOutput($sformatf("inv_gap%0d", k), t - prevT, gap);
      prevT = t;
    end
    checkOutput("inv_err_sticky", cfgErr, 1);

    // Valid load landing on the wrap cycle: the due tick must be dropped.
    gap = nextGap();
    repeat (gap - 1) @(negedge clk);
    applyStimulus(1'b1, 10, 0, 1'b0);
    checkOutput("load_suppress", tick, 0);
    checkOutput("load_err_clear", cfgErr, 0);
    prevT = cycleCnt;
    for (int k = 1; k <= 5; k++) begin
      waitTick(30, t, b, m);
      checkOutput($sformatf("div10_gap%0d", k), t - prevT, 10);
      prevT = t;
    end

    // Resync landing on the wrap cycle after 5 ticks of the bit.
    repeat (9) @(negedge clk);
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("resync_suppress", tick, 0);
    prevT = cycleCnt;
    for (int k = 1; k <= 16; k++) begin
      waitTick(30, t, b, m);
      checkOutput($sformatf("resync_gap%0d", k), t - prevT, 10);
      checkOutput($sformatf("resync_mid%0d", k), m, (k == 8) ? 1 : 0);
      checkOutput($sformatf("resync_bit%0d", k), b, (k == 16) ? 1 : 0);
      prevT = t;
    end

    // Integer mode 326 + 0/16: exact period, bit tick every 5216 clocks.
    applyStimulus(1'b1, 326, 0, 1'b0);
    prevT   = cycleCnt;
    okGaps  = 0;
    bitCnt  = 0;
    midCnt  = 0;
    lastBit = 0;
    for (int k = 1; k <= 48; k++) begin
      waitTick(400, t, b, m);
      if (t - prevT == 326) okGaps++;
      if (b === 1'b1) begin
        bitCnt++;
        if (k == 16) lastBit = t;
        if (k == 32) checkOutput("int_bit_span", t - lastBit, 5216);
      end
      if (m === 1'b1) midCnt++;
      if (k == 16) checkOutput("int_bit16", b, 1);
      if (k == 24) checkOutput("int_mid24", m, 1);
      prevT = t;
    end
    checkOutput("int_gaps_ok", okGaps, 48);
    checkOutput("int_bit_count", bitCnt, 3);
    checkOutput("int_mid_count", midCnt, 3);

    // Asynchronous reset while a tick and the error flag are both high.
    applyStimulus(1'b1, 0, 0, 1'b0);
    checkOutput("pre_reset_err", cfgErr, 1);
    waitTick(400, t, b, m);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async_tick", tick, 0);
    checkOutput("async_err", cfgErr, 0);
    checkOutput("async_bit", bitTick, 0);
    checkOutput("async_mid", midTick, 0);
    @(negedge clk);
    resetN = 1'b1;
    prevT  = cycleCnt;
    waitTick(400, t, b, m);
    checkOutput("post_reset_gap1", t - prevT, 325);
    prevT = t;
    waitTick(400, t, b, m);
    checkOutput("post_reset_gap2", t - prevT, 326);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
